fwd_hazard_unit: RTL and testbench

- Next-generation operand forwarding and hazard unit for the pipelined RNS core.
- Resolves up to NUM_OPS ID-stage source operands against three producers, youngest first:
  - the EX-stage result;
  - the WB-stage write;
  - a HIST_DEPTH-deep history of retired writes.
- Detects load-use hazards and holds the front end with a multi-cycle stall FSM sized by LOAD_LAT.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/fwd_hazard_unit.sv | 195 +++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit: resolves ID source operands against the
// EX result, the WB write and a short history of retired writes, and stalls on load-use.

module fwd_op_resolve #(
    parameter int W          = 8,
    parameter int ADDR_W     = 4,
    parameter int HIST_DEPTH = 2,
    parameter int ZERO_REG   = 0
) (
    input  logic                              op_valid_i,
    input  logic [ADDR_W-1:0]                 op_addr_i,
    input  logic [W-1:0]                      rf_data_i,
    input  logic                              ex_wr_en_i,
    input  logic [ADDR_W-1:0]                 ex_wr_addr_i,
    input  logic [W-1:0]                      ex_wr_data_i,
    input  logic                              ex_is_load_i,
    input  logic                              wb_wr_en_i,
    input  logic [ADDR_W-1:0]                 wb_wr_addr_i,
    input  logic [W-1:0]                      wb_wr_data_i,
    input  logic [HIST_DEPTH-1:0]             hist_vld_i,
    input  logic [HIST_DEPTH-1:0][ADDR_W-1:0] hist_addr_i,
    input  logic [HIST_DEPTH-1:0][W-1:0]      hist_data_i,
    output logic [W-1:0]                      data_o,
    output logic [1:0]                        sel_o,
    output logic                              load_hit_o
);
    logic addr_ok;
    logic ex_hit;
    logic wb_hit;

    assign addr_ok    = op_valid_i && !((ZERO_REG != 0) && (op_addr_i == '0));
    assign ex_hit     = addr_ok && ex_wr_en_i && (ex_wr_addr_i == op_addr_i);
    assign wb_hit     = addr_ok && wb_wr_en_i && (wb_wr_addr_i == op_addr_i);
    assign load_hit_o = ex_hit && ex_is_load_i;

    always_comb begin
        data_o = rf_data_i;
        sel_o  = 2'd0;
        // Scan oldest to youngest so the youngest matching entry overrides.
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            if (addr_ok && hist_vld_i[i] && (hist_addr_i[i] == op_addr_i)) begin
                data_o = hist_data_i[i];
                sel_o  = 2'd1;
            end
        end
        if (wb_hit) begin
            data_o = wb_wr_data_i;
            sel_o  = 2'd2;
        end
        if (ex_hit && !ex_is_load_i) begin
            data_o = ex_wr_data_i;
            sel_o  = 2'd3;
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int NUM_DOMAINS = 1,
    parameter int ADDR_W      = 4,
    parameter int NUM_OPS     = 3,
    parameter int HIST_DEPTH  = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG    = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_OPS-1:0]                     id_op_valid,
    input  logic [NUM_OPS-1:0][ADDR_W-1:0]         id_op_addr,
    input  logic [NUM_OPS-1:0][NUM_DOMAINS*8-1:0]  id_rf_data,
    input  logic                                   ex_wr_en,
    input  logic [ADDR_W-1:0]                      ex_wr_addr,
    input  logic [NUM_DOMAINS*8-1:0]               ex_wr_data,
    input  logic                                   ex_is_load,
    input  logic                                   wb_wr_en,
    input  logic [ADDR_W-1:0]                      wb_wr_addr,
    input  logic [NUM_DOMAINS*8-1:0]               wb_wr_data,
    output logic [NUM_OPS-1:0][NUM_DOMAINS*8-1:0]  id_op_data,
    output logic [NUM_OPS-1:0][1:0]                id_fwd_sel,
    output logic                                   stall,
    output logic [15:0]                            stall_cycles
);
    localparam int W = NUM_DOMAINS * 8;
    localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    typedef enum logic {S_IDLE, S_STALL} state_t;

    logic [HIST_DEPTH-1:0]             hist_vld_q,  hist_vld_d;
    logic [HIST_DEPTH-1:0][ADDR_W-1:0] hist_addr_q, hist_addr_d;
    logic [HIST_DEPTH-1:0][W-1:0]      hist_data_q, hist_data_d;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic [NUM_OPS-1:0] op_load_hit;
    logic               load_use_hit;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        fwd_op_resolve #(
            .W         (W),
            .ADDR_W    (ADDR_W),
            .HIST_DEPTH(HIST_DEPTH),
            .ZERO_REG  (ZERO_REG)
        ) u_res (
            .op_valid_i  (id_op_valid[g]),
            .op_addr_i   (id_op_addr[g]),
            .rf_data_i   (id_rf_data[g]),
            .ex_wr_en_i  (ex_wr_en),
            .ex_wr_addr_i(ex_wr_addr),
            .ex_wr_data_i(ex_wr_data),
            .ex_is_load_i(ex_is_load),
            .wb_wr_en_i  (wb_wr_en),
            .wb_wr_addr_i(wb_wr_addr),
            .wb_wr_data_i(wb_wr_data),
            .hist_vld_i  (hist_vld_q),
            .hist_addr_i (hist_addr_q),
            .hist_data_i (hist_data_q),
            .data_o      (id_op_data[g]),
            .sel_o       (id_fwd_sel[g]),
            .load_hit_o  (op_load_hit[g])
        );
    end

    assign load_use_hit = |op_load_hit;
    assign stall        = load_use_hit || (state_q == S_STALL);
    assign stall_cycles = stall_cycles_q;

    // History only advances on a WB write; stall and flush leave it alone.
    always_comb begin
        hist_vld_d  = hist_vld_q;
        hist_addr_d = hist_addr_q;
        hist_data_d = hist_data_q;
        if (wb_wr_en) begin
            hist_vld_d[0]  = 1'b1;
            hist_addr_d[0] = wb_wr_addr;
            hist_data_d[0] = wb_wr_data;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist_vld_d[i]  = hist_vld_q[i-1];
                hist_addr_d[i] = hist_addr_q[i-1];
                hist_data_d[i] = hist_data_q[i-1];
            end
        end
    end

    // The hit cycle itself is the first stall cycle; STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_use_hit && !flush && (LOAD_LAT > 1)) begin
                    state_d = S_STALL;
                    cnt_d   = CNT_INIT;
                end
            end
            S_STALL: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld_q     <= '0;
            hist_addr_q    <= '0;
            hist_data_q    <= '0;
            state_q        <= S_IDLE;
            cnt_q          <= 2'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            hist_vld_q     <= hist_vld_d;
            hist_addr_q    <= hist_addr_d;
            hist_data_q    <= hist_data_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two configurations share one random/directed stimulus stream and are
// checked every cycle against a log-based reference model.

module tb_fwd_hazard_unit;
    localparam int NOPS = 3;
    localparam int AW   = 4;
    localparam int W    = 8;

    // dut 0: HIST_DEPTH 2, LOAD_LAT 3, ZERO_REG 0; dut 1: HIST_DEPTH 1, LOAD_LAT 4, ZERO_REG 1
    function automatic int hd(input int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int ll(input int d); return (d == 0) ? 3 : 4; endfunction
    function automatic bit zr(input int d); return d != 0; endfunction

    logic clk = 1'b0;
    logic rst, flush;
    logic [NOPS-1:0]    id_op_valid;
    logic [NOPS*AW-1:0] id_op_addr;
    logic [NOPS*W-1:0]  id_rf_data;
    logic               ex_wr_en, ex_is_load, wb_wr_en;
    logic [AW-1:0]      ex_wr_addr, wb_wr_addr;
    logic [W-1:0]       ex_wr_data, wb_wr_data;
    logic [NOPS*W-1:0]  data_a, data_b;
    logic [NOPS*2-1:0]  sel_a, sel_b;
    logic               stall_a, stall_b;
    logic [15:0]        cyc_a, cyc_b;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_DOMAINS(1), .ADDR_W(AW), .NUM_OPS(NOPS), .HIST_DEPTH(2),
                      .LOAD_LAT(3), .ZERO_REG(0)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush), .id_op_valid(id_op_valid),
        .id_op_addr(id_op_addr), .id_rf_data(id_rf_data), .ex_wr_en(ex_wr_en),
        .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .id_op_data(data_a), .id_fwd_sel(sel_a), .stall(stall_a), .stall_cycles(cyc_a));

    fwd_hazard_unit #(.NUM_DOMAINS(1), .ADDR_W(AW), .NUM_OPS(NOPS), .HIST_DEPTH(1),
                      .LOAD_LAT(4), .ZERO_REG(1)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush), .id_op_valid(id_op_valid),
        .id_op_addr(id_op_addr), .id_rf_data(id_rf_data), .ex_wr_en(ex_wr_en),
        .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .id_op_data(data_b), .id_fwd_sel(sel_b), .stall(stall_b), .stall_cycles(cyc_b));

    typedef struct packed {
        bit                     chk;
        logic [1:0][NOPS*W-1:0] data;
        logic [1:0][NOPS*2-1:0] sel;
        logic [1:0]             stall;
        logic [1:0][15:0]       cyc;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    exp_t q[$];
    wr_t  wb_log[$];      // retired WB writes since last reset, newest at the back
    int   m_rem[2];       // stall cycles still owed after the current one
    int   m_cnt[2];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, d, $time, got, exp);
        end
    endtask

    // Reference resolution straight from the priority rules.
    function automatic void resolve(input int d, input int i, output logic [W-1:0] dat,
                                    output logic [1:0] sel, output bit hit);
        logic [AW-1:0] a;
        bit ok;
        a   = id_op_addr[i*AW +: AW];
        ok  = id_op_valid[i] && !(zr(d) && a == 0);
        dat = id_rf_data[i*W +: W];
        sel = 2'd0;
        hit = ok && ex_wr_en && ex_wr_addr == a && ex_is_load;
        if (ok && ex_wr_en && ex_wr_addr == a && !ex_is_load) begin
            dat = ex_wr_data; sel = 2'd3; return;
        end
        if (ok && wb_wr_en && wb_wr_addr == a) begin
            dat = wb_wr_data; sel = 2'd2; return;
        end
        if (ok) begin
            for (int k = 0; k < hd(d) && k < wb_log.size(); k++) begin
                if (wb_log[wb_log.size()-1-k].a == a) begin
                    dat = wb_log[wb_log.size()-1-k].d; sel = 2'd1; return;
                end
            end
        end
    endfunction

    task automatic step(input bit chk);
        exp_t e;
        logic [W-1:0] dat;
        logic [1:0] sel;
        bit h, hit;
        e = '0;
        e.chk = chk;
        for (int d = 0; d < 2; d++) begin
            hit = 0;
            for (int i = 0; i < NOPS; i++) begin
                resolve(d, i, dat, sel, h);
                e.data[d][i*W +: W] = dat;
                e.sel[d][i*2 +: 2]  = sel;
                hit |= h;
            end
            e.stall[d] = hit || (m_rem[d] > 0);
            e.cyc[d]   = 16'(m_cnt[d]);
            if (rst) begin
                m_rem[d] = 0; m_cnt[d] = 0;
            end else begin
                if (e.stall[d] && m_cnt[d] < 65535) m_cnt[d]++;
                if (flush)            m_rem[d] = 0;
                else if (m_rem[d] > 0) m_rem[d]--;
                else if (hit)         m_rem[d] = ll(d) - 1;
            end
        end
        q.push_back(e);
        if (rst) wb_log.delete();
        else if (wb_wr_en) begin
            wb_log.push_back('{a: wb_wr_addr, d: wb_wr_data});
            if (wb_log.size() > 4) void'(wb_log.pop_front());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        flush = 0; ex_wr_en = 0; ex_is_load = 0; wb_wr_en = 0; id_op_valid = '0;
        ex_wr_addr = AW'($urandom); wb_wr_addr = AW'($urandom);
        ex_wr_data = W'($urandom);  wb_wr_data = W'($urandom);
        id_op_addr = (NOPS*AW)'($urandom); id_rf_data = (NOPS*W)'($urandom);
    endtask

    task automatic set_op(input int i, input int a);
        id_op_valid[i] = 1'b1;
        id_op_addr[i*AW +: AW] = AW'(a);
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    cmp("op_data", 0, 32'(data_a), 32'(e.data[0]));
                    cmp("fwd_sel", 0, 32'(sel_a), 32'(e.sel[0]));
                    cmp("stall", 0, 32'(stall_a), 32'(e.stall[0]));
                    cmp("stall_cycles", 0, 32'(cyc_a), 32'(e.cyc[0]));
                    cmp("op_data", 1, 32'(data_b), 32'(e.data[1]));
                    cmp("fwd_sel", 1, 32'(sel_b), 32'(e.sel[1]));
                    cmp("stall", 1, 32'(stall_b), 32'(e.stall[1]));
                    cmp("stall_cycles", 1, 32'(cyc_b), 32'(e.cyc[1]));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1);
    end

    initial begin
        m_rem = '{0, 0}; m_cnt = '{0, 0};
        rst = 1; clr();
        @(posedge clk); #2;
        step(0); step(1);
        rst = 0; clr(); step(1);

        // EX over WB, then WB alone
        clr(); ex_wr_en = 1; ex_wr_addr = 3; ex_wr_data = 8'h11;
        wb_wr_en = 1; wb_wr_addr = 3; wb_wr_data = 8'h22; set_op(0, 3); step(1);
        ex_wr_en = 0; step(1);

        // history hit, then eviction in the depth-1 instance
        clr(); wb_wr_en = 1; wb_wr_addr = 5; wb_wr_data = 8'hA5; step(1);
        clr(); set_op(1, 5); step(1); step(1);
        clr(); wb_wr_en = 1; wb_wr_addr = 6; wb_wr_data = 8'h66; step(1);
        clr(); set_op(1, 5); step(1);

        // load-use: load then reaches WB while the consumer waits
        clr(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 2; set_op(2, 2); step(1);
        clr(); wb_wr_en = 1; wb_wr_addr = 2; wb_wr_data = 8'h5C; set_op(2, 2); step(1);
        clr(); set_op(2, 2); repeat (4) step(1);

        // flush on the second stall cycle
        clr(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 7; set_op(0, 7); step(1);
        clr(); flush = 1; step(1);
        clr(); repeat (3) step(1);

        // register 0 load: stalls only where r0 is not hardwired
        clr(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 0; ex_wr_data = 8'hFF; set_op(0, 0); step(1);
        clr(); ex_wr_en = 1; ex_wr_addr = 0; ex_wr_data = 8'hFF; set_op(0, 0); step(1);
        clr(); repeat (4) step(1);

        // reset in the middle of a stall
        clr(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 9; set_op(1, 9); step(1);
        clr(); step(1);
        rst = 1; step(1);
        rst = 0; clr(); set_op(0, 5); set_op(1, 6); set_op(2, 3); step(1); step(1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clr();
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            ex_wr_en   = $urandom_range(0, 1);
            ex_is_load = ($urandom_range(0, 5) == 0);
            wb_wr_en   = $urandom_range(0, 1);
            ex_wr_addr = AW'($urandom_range(0, 7));
            wb_wr_addr = AW'($urandom_range(0, 7));
            for (int i = 0; i < NOPS; i++)
                if ($urandom_range(0, 3) != 0) set_op(i, $urandom_range(0, 7));
            step(1);
        end
        rst = 0;

        // saturation: a held hit with flush stalls every cycle without entering STALL
        rst = 1; clr(); step(1);
        rst = 0;
        clr(); flush = 1; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 1; set_op(0, 1);
        repeat (65540) step(1);
        clr(); step(1); step(1);
        rst = 1; step(1);
        rst = 0; step(1);

        cmp("queue_drain", 0, 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
